// File: rtl/riscv_alu_mul_seq_if.sv
// Core-side request/response bundle for the iterative multiply sequencer.
interface riscv_alu_mul_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            start_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Issuing side (execute-stage control)
  modport master (
    output start_i, a_i, b_i, flush_i,
    input  ready_o, done_o, result_o
  );

  // Sequencer side
  modport slave (
    input  start_i, a_i, b_i, flush_i,
    output ready_o, done_o, result_o
  );
endinterface

// File: rtl/riscv_alu_mul_seq.sv
// Shift-add multiply sequencer: borrows the shared combinational ALU for one
// add per cycle and returns the low XLEN bits of an unsigned product.
module riscv_alu_mul_seq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  riscv_alu_mul_seq_if.slave  bus,
  output logic [3:0]          alu_ctl_o,
  output logic [XLEN-1:0]     alu_a_o,
  output logic [XLEN-1:0]     alu_b_o,
  input  logic [XLEN-1:0]     alu_out_i
);

  localparam logic [3:0]       AluAdd  = 4'd2;
  localparam logic [3:0]       AluIdle = 4'd15;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state: accept, one partial-product add per RUN cycle, abort on flush
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.flush_i && bus.start_i) begin
          mcand_d  = bus.a_i;
          mplier_d = bus.b_i;
          acc_d    = '0;
          cnt_d    = '0;
          // A zero operand needs no iterations
          if (bus.a_i == '0 || bus.b_i == '0) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        if (bus.flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d    = alu_out_i;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          // Stop once no multiplier bits remain above the current one
          if ((mplier_q >> 1) == '0 || cnt_q == CntLast) begin
            result_d = alu_out_i;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; ALU held at the idle code outside RUN
  always_comb begin
    bus.ready_o  = (state_q == StIdle);
    bus.done_o   = (state_q == StDone);
    bus.result_o = result_q;
    alu_ctl_o    = AluIdle;
    alu_a_o      = '0;
    alu_b_o      = '0;
    if (state_q == StRun) begin
      alu_ctl_o = AluAdd;
      alu_a_o   = acc_q;
      alu_b_o   = mplier_q[0] ? mcand_q : '0;
    end
  end

endmodule

// File: tb/tb_riscv_alu_mul_seq.sv
// Bench for riscv_alu_mul_seq: per-cycle comparison against a product-level
// model, directed scenarios with literal expectations, then random operands.
module tb_riscv_alu_mul_seq;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;

  int total = 0;
  int bad   = 0;

  riscv_alu_mul_seq_if #(.XLEN(XLEN)) bus ();

  riscv_alu_mul_seq #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .alu_ctl_o (alu_ctl),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_out_i (alu_out)
  );

  // Shared ALU stand-in: add on code 2, zero on the idle code
  assign alu_out = (alu_ctl == 4'd2) ? alu_a + alu_b : '0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb(input logic [XLEN-1:0] v);
    for (int i = XLEN - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural model: an operation is "busy" for end_cyc cycles after the
  // accept edge; cycles 1..end_cyc-1 are RUN, cycle end_cyc is DONE.
  bit              m_busy = 1'b0;
  int              m_k    = 0;
  int              m_end  = 0;
  logic [XLEN-1:0] m_a    = '0;
  logic [XLEN-1:0] m_b    = '0;
  logic [XLEN-1:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_end  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_res  <= '0;
    end else if (bus.flush_i) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (bus.start_i) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_a    <= bus.a_i;
        m_b    <= bus.b_i;
        if (bus.a_i == '0 || bus.b_i == '0) begin
          m_end <= 1;
          m_res <= '0;
        end else begin
          m_end <= msb(bus.b_i) + 2;
        end
      end
    end else if (m_k == m_end) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_end) m_res <= m_a * m_b;
    end
  end

  // Per-cycle compare: accumulator before step j is a * (b mod 2^j)
  always @(negedge clk) begin
    automatic bit              run = m_busy && (m_k < m_end);
    automatic int              j   = m_k - 1;
    automatic logic [XLEN-1:0] mask, ea, eb;
    mask = '0;
    ea   = '0;
    eb   = '0;
    if (run) begin
      mask = (64'd1 << j) - 64'd1;
      ea   = m_a * (m_b & mask);
      eb   = m_b[j] ? (m_a << j) : '0;
    end
    chk("ready", {63'd0, bus.ready_o}, {63'd0, !m_busy});
    chk("done", {63'd0, bus.done_o}, {63'd0, m_busy && (m_k == m_end)});
    chk("result", bus.result_o, m_res);
    chk("alu_ctl", {60'd0, alu_ctl}, run ? 64'd2 : 64'd15);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
  end

  logic [XLEN-1:0] bseq[$];

  // Present a,b with start for one cycle; returns just after the accept edge
  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Issue and follow an operation; cycle numbers count from the accept edge
  task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int flush_at, input int poke_at,
                       output int done_cyc, output logic [XLEN-1:0] res_seen);
    done_cyc = 0;
    res_seen = 'x;
    bseq.delete();
    issue(a, b);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (alu_ctl == 4'd2) bseq.push_back(alu_b);
      if (bus.done_o) begin
        done_cyc = c;
        res_seen = bus.result_o;
        break;
      end
      if (flush_at > 0 && c == flush_at + 1) begin
        bus.flush_i = 1'b0;
        break;
      end
      if (c == flush_at) bus.flush_i = 1'b1;
      if (c == poke_at) begin
        bus.start_i = 1'b1;
        bus.a_i     = {$urandom, $urandom};
        bus.b_i     = {$urandom, $urandom};
      end
      if (poke_at > 0 && c == poke_at + 1) bus.start_i = 1'b0;
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    if (done_cyc == 0 && flush_at <= 0) begin
      total++;
      bad++;
      $display("FAIL timeout actual=no_done required=done a=%h b=%h", a, b);
    end
  endtask

  initial begin
    int              dc;
    logic [XLEN-1:0] rs;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;

    // Reset values
    #3;
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("rst_done", {63'd0, bus.done_o}, 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ctl", {60'd0, alu_ctl}, 64'd15);
    #9 rst_n = 1'b1;

    // 3 * 5: three RUN cycles with alu_b 3,0,12
    do_op(64'd3, 64'd5, 0, 0, dc, rs);
    chk("m35_cycle", 64'(dc), 64'd4);
    chk("m35_result", rs, 64'd15);
    chk("m35_nrun", 64'(bseq.size()), 64'd3);
    if (bseq.size() == 3) begin
      chk("m35_b0", bseq[0], 64'd3);
      chk("m35_b1", bseq[1], 64'd0);
      chk("m35_b2", bseq[2], 64'd12);
    end

    // Wrapping product
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, dc, rs);
    chk("wrap_cycle", 64'(dc), 64'd3);
    chk("wrap_result", rs, 64'hFFFF_FFFF_FFFF_FFFE);

    // Zero multiplier: fast path, ALU never used
    do_op(64'h1234, 64'd0, 0, 0, dc, rs);
    chk("zero_cycle", 64'(dc), 64'd1);
    chk("zero_result", rs, 64'd0);
    chk("zero_nrun", 64'(bseq.size()), 64'd0);

    // Worst case with an ignored start mid-RUN
    do_op(64'd3, 64'h8000_0000_0000_0000, 0, 20, dc, rs);
    chk("top_cycle", 64'(dc), 64'd65);
    chk("top_result", rs, 64'h8000_0000_0000_0000);
    chk("top_nrun", 64'(bseq.size()), 64'd64);

    // Flush in RUN cycle 3: no done, result keeps previous value
    do_op(64'd7, 64'hFF, 3, 0, dc, rs);
    chk("flush_nodone", 64'(dc), 64'd0);
    chk("flush_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("flush_result", bus.result_o, 64'h8000_0000_0000_0000);

    // start with flush in IDLE is not accepted
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.a_i     = 64'd9;
    bus.b_i     = 64'd9;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("sf_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("sf_ctl", {60'd0, alu_ctl}, 64'd15);

    // Asynchronous reset between edges in the middle of RUN
    issue(64'd7, 64'hFF);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("arst_done", {63'd0, bus.done_o}, 64'd0);
    chk("arst_result", bus.result_o, 64'd0);
    chk("arst_ctl", {60'd0, alu_ctl}, 64'd15);
    chk("arst_a", alu_a, 64'd0);
    chk("arst_b", alu_b, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(64'd2, 64'd3, 0, 0, dc, rs);
    chk("post_rst_result", rs, 64'd6);

    // Random operands, occasional zero operands, flushes and stray starts
    for (int n = 0; n < 40; n++) begin
      automatic logic [XLEN-1:0] a = {$urandom, $urandom};
      automatic logic [XLEN-1:0] b = {$urandom, $urandom} >> $urandom_range(0, 63);
      automatic int              e, fl, pk;
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '0;
      e  = (a == '0 || b == '0) ? 1 : msb(b) + 2;
      fl = 0;
      pk = 0;
      if (e > 2 && $urandom_range(0, 4) == 0) fl = $urandom_range(1, e - 1);
      else if (e > 4 && $urandom_range(0, 3) == 0) pk = $urandom_range(1, e - 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(a, b, fl, pk, dc, rs);
      if (fl > 0) begin
        chk("rnd_flush_nodone", 64'(dc), 64'd0);
      end else begin
        chk("rnd_cycle", 64'(dc), 64'(e));
        chk("rnd_result", rs, a * b);
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
